drysponge_mix_seq: RTL and testbench

//  Producer side of the DrySponge mix phase: accepts one rate block plus its domain

---
 rtl/drysponge_mix_seq.sv | 129 ++++++++++++
 tb/tb_drysponge_mix_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/drysponge_mix_seq.sv
// -----------------------------------------------------------------------------
// drysponge_mix_seq
//
// Producer side of the DrySponge mix phase. It accepts one rate block and its
// domain separator, then hands them to the mix datapath as a sequence of
// 2*CW-bit selector fields, one per round. Field i of a round (d_o[2*i +: 2])
// selects which of the four 32-bit x words is XORed into capacity word i.
//
// The message is M = {zero pad, ds_i, blk_i}, consumed LSB first, so that
// round r presents M[2*CW*r +: 2*CW].
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, active low
//   blk_i        rate block (BW bits), sampled only on accept
//   ds_i         domain separator (DSW bits), sampled only on accept
//   blk_valid_i  blk_i/ds_i valid
//   blk_ready_o  high in IDLE; block accepted when valid & ready
//   abort_i      drop the current block and return to IDLE
//   d_o          selector fields of the round currently presented
//   d_valid_o    d_o valid (high in RUN)
//   d_ready_i    mix datapath consumes d_o this cycle
//   d_last_o     current d_o is the final round of the block
//   round_o      index of the round currently presented
//   busy_o       high in RUN
// -----------------------------------------------------------------------------
module drysponge_mix_seq #(
  parameter  int CW     = 5,
  parameter  int BW     = 128,
  parameter  int DSW    = 4,
  localparam int ROUNDS = (BW + DSW + 2*CW - 1) / (2*CW),
  localparam int RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BW-1:0]    blk_i,
  input  logic [DSW-1:0]   ds_i,
  input  logic             blk_valid_i,
  output logic             blk_ready_o,
  input  logic             abort_i,
  output logic [2*CW-1:0]  d_o,
  output logic             d_valid_o,
  input  logic             d_ready_i,
  output logic             d_last_o,
  output logic [RW-1:0]    round_o,
  output logic             busy_o
);

  localparam int DW = 2 * CW;
  localparam int SW = DW * ROUNDS;
  localparam int MW = BW + DSW;
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q;
  logic [SW-1:0]   shreg_q;
  logic [SW-1:0]   shreg_d;
  logic [RW-1:0]   round_q;
  logic [RW-1:0]   round_d;
  logic [SW-1:0]   loadImage;
  logic            accept;
  logic            advance;
  logic            lastRound;

  assign accept    = (state_q == IDLE) && blk_valid_i;
  assign advance   = (state_q == RUN) && d_ready_i;
  assign lastRound = (round_q == LAST_ROUND);

  // Message image as loaded into the shift register: block in the low bits,
  // separator directly above it, zero padding up to a whole number of rounds.
  always_comb begin
    loadImage           = '0;
    loadImage[MW-1:0]   = {ds_i, blk_i};
  end

  // Next shift-register and round-counter values. Abort clears everything so
  // a dropped block leaves no residue on d_o. The final handshake only ends the
  // block; there is nothing left to shift.
  always_comb begin
    shreg_d = shreg_q;
    round_d = round_q;
    if (abort_i) begin
      shreg_d = '0;
      round_d = '0;
    end else if (accept) begin
      shreg_d = loadImage;
      round_d = '0;
    end else if (advance && !lastRound) begin
      shreg_d = shreg_q >> DW;
      round_d = round_q + RW'(1);
    end
  end

  // Control FSM and datapath registers. Abort has priority over both accept
  // and handshake, so an aborted round is never counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      round_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      round_q <= round_d;
      if (abort_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE:    if (blk_valid_i) state_q <= RUN;
          RUN:     if (d_ready_i && lastRound) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // All outputs decode directly from registers, so they are stable for the
  // whole cycle and hold under backpressure.
  assign blk_ready_o = (state_q == IDLE);
  assign d_valid_o   = (state_q == RUN);
  assign busy_o      = (state_q == RUN);
  assign d_last_o    = (state_q == RUN) && lastRound;
  assign d_o         = shreg_q[DW-1:0];
  assign round_o     = round_q;

endmodule

// File: tb/tb_drysponge_mix_seq.sv
// -----------------------------------------------------------------------------
// tb_drysponge_mix_seq
//
// Directed bench for drysponge_mix_seq. A behavioural model tracks whether a
// block is in flight, which round is presented and the whole message as one
// wide vector; a negedge process compares every output against it each cycle.
// Hand-computed literal values at key rounds pin the model itself.
// -----------------------------------------------------------------------------
module tb_drysponge_mix_seq;

  localparam int CW = 5;
  localparam int BW = 128;
  localparam int DSW = 4;
  localparam int DW = 2 * CW;
  localparam int NR = 14;
  localparam int MW = DW * NR;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [BW-1:0]   blk_i;
  logic [DSW-1:0]  ds_i;
  logic            blk_valid_i;
  logic            blk_ready_o;
  logic            abort_i;
  logic [DW-1:0]   d_o;
  logic            d_valid_o;
  logic            d_ready_i;
  logic            d_last_o;
  logic [3:0]      round_o;
  logic            busy_o;

  int vecCount  = 0;
  int failCount = 0;

  drysponge_mix_seq #(.CW(CW), .BW(BW), .DSW(DSW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .blk_i       (blk_i),
    .ds_i        (ds_i),
    .blk_valid_i (blk_valid_i),
    .blk_ready_o (blk_ready_o),
    .abort_i     (abort_i),
    .d_o         (d_o),
    .d_valid_o   (d_valid_o),
    .d_ready_i   (d_ready_i),
    .d_last_o    (d_last_o),
    .round_o     (round_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: one block in flight at most; the round presented is
  // simply a slice of the message vector.
  bit             mLive  = 1'b0;
  bit             mBusy  = 1'b0;
  int             mRound = 0;
  logic [MW-1:0]  mMsg   = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mLive  = 1'b1;
      mBusy  = 1'b0;
      mRound = 0;
      mMsg   = '0;
    end else if (abort_i) begin
      mBusy = 1'b0;
    end else if (!mBusy) begin
      if (blk_valid_i) begin
        mBusy  = 1'b1;
        mRound = 0;
        mMsg   = MW'({ds_i, blk_i});
      end
    end else if (d_ready_i) begin
      if (mRound == NR - 1) mBusy = 1'b0;
      else mRound++;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vecCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mLive) begin
      checkOutput("blk_ready", 16'(blk_ready_o), 16'(!mBusy));
      checkOutput("d_valid", 16'(d_valid_o), 16'(mBusy));
      checkOutput("busy", 16'(busy_o), 16'(mBusy));
      checkOutput("d_last", 16'(d_last_o), 16'(mBusy && (mRound == NR - 1)));
      if (mBusy) begin
        checkOutput("d_model", 16'(d_o), 16'(mMsg[DW*mRound +: DW]));
        checkOutput("round_model", 16'(round_o), 16'(mRound));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [BW-1:0] blk, input logic [DSW-1:0] ds,
                               input logic ready, input logic abrt);
    blk_valid_i = valid;
    blk_i       = blk;
    ds_i        = ds;
    d_ready_i   = ready;
    abort_i     = abrt;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_blk_ready"}, 16'(blk_ready_o), 16'd1);
    checkOutput({tag, "_d_valid"}, 16'(d_valid_o), 16'd0);
    checkOutput({tag, "_d"}, 16'(d_o), 16'd0);
    checkOutput({tag, "_round"}, 16'(round_o), 16'd0);
    checkOutput({tag, "_busy"}, 16'(busy_o), 16'd0);
    checkOutput({tag, "_d_last"}, 16'(d_last_o), 16'd0);
  endtask

  // Steps through a full block with d_ready_i high, checking literal d_o
  // values: eLow for rounds 0..11, then e12 and e13.
  task automatic runLiteral(input string tag, input logic [DW-1:0] eLow,
                            input logic [DW-1:0] e12, input logic [DW-1:0] e13);
    logic [DW-1:0] e;
    for (int r = 0; r < NR; r++) begin
      e = (r < 12) ? eLow : ((r == 12) ? e12 : e13);
      checkOutput({tag, "_round"}, 16'(round_o), 16'(r));
      checkOutput({tag, "_d"}, 16'(d_o), 16'(e));
      checkOutput({tag, "_last"}, 16'(d_last_o), 16'(r == NR - 1));
      checkOutput({tag, "_ready_low"}, 16'(blk_ready_o), 16'd0);
      tick();
    end
    checkOutput({tag, "_ready_back"}, 16'(blk_ready_o), 16'd1);
    checkOutput({tag, "_valid_off"}, 16'(d_valid_o), 16'd0);
  endtask

  initial begin
    logic [DW-1:0] heldExp;

    // Reset held for two cycles.
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    checkResetValues("reset");
    rst_n = 1'b1;
    tick();

    // All-ones block, zero separator.
    applyStimulus(1'b1, '1, 4'h0, 1'b1, 1'b0);
    tick();
    blk_valid_i = 1'b0;
    runLiteral("ones", 10'h3FF, 10'h0FF, 10'h000);

    // Zero block, separator 4'hA.
    applyStimulus(1'b1, '0, 4'hA, 1'b1, 1'b0);
    tick();
    blk_valid_i = 1'b0;
    runLiteral("ds", 10'h000, 10'h200, 10'h002);

    // Backpressure for five cycles at round 3.
    applyStimulus(1'b1, {$urandom, $urandom, $urandom, $urandom}, 4'h5, 1'b1, 1'b0);
    tick();
    blk_valid_i = 1'b0;
    repeat (3) tick();
    d_ready_i = 1'b0;
    heldExp = mMsg[3*DW +: DW];
    repeat (5) begin
      tick();
      checkOutput("bp_round", 16'(round_o), 16'd3);
      checkOutput("bp_d", 16'(d_o), 16'(heldExp));
    end
    d_ready_i = 1'b1;
    repeat (11) tick();
    checkOutput("bp_done", 16'(blk_ready_o), 16'd1);

    // Abort at round 6 with d_ready_i high.
    applyStimulus(1'b1, {4{32'h1234_5678}}, 4'h3, 1'b1, 1'b0);
    tick();
    blk_valid_i = 1'b0;
    repeat (6) tick();
    checkOutput("abort_at_round", 16'(round_o), 16'd6);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checkOutput("abort_ready", 16'(blk_ready_o), 16'd1);
    checkOutput("abort_valid", 16'(d_valid_o), 16'd0);
    checkOutput("abort_d_cleared", 16'(d_o), 16'd0);
    applyStimulus(1'b1, 128'h3C5, 4'h0, 1'b0, 1'b0);
    tick();
    blk_valid_i = 1'b0;
    checkOutput("post_abort_round", 16'(round_o), 16'd0);
    checkOutput("post_abort_d", 16'(d_o), 16'h3C5);
    checkOutput("post_abort_valid", 16'(d_valid_o), 16'd1);
    abort_i = 1'b1;
    tick();
    // Abort in IDLE beats a simultaneous valid block.
    applyStimulus(1'b1, 128'h111, 4'h0, 1'b1, 1'b1);
    tick();
    checkOutput("idle_abort_ready", 16'(blk_ready_o), 16'd1);
    checkOutput("idle_abort_valid", 16'(d_valid_o), 16'd0);
    applyStimulus(1'b0, '0, 4'h0, 1'b1, 1'b0);
    tick();
    checkOutput("idle_abort_still", 16'(d_valid_o), 16'd0);

    // Reset in the middle of a block.
    applyStimulus(1'b1, {4{32'hDEAD_BEEF}}, 4'hC, 1'b1, 1'b0);
    tick();
    blk_valid_i = 1'b0;
    repeat (4) tick();
    checkOutput("mid_rst_round", 16'(round_o), 16'd4);
    rst_n = 1'b0;
    tick();
    checkResetValues("mid_reset");
    rst_n = 1'b1;

    // blk_valid_i held high across a whole block; input data changed after
    // accept must not disturb the block in flight.
    applyStimulus(1'b1, {4{32'hCAFE_F00D}}, 4'h9, 1'b1, 1'b0);
    tick();
    blk_i = 128'h2A7;
    ds_i  = 4'h0;
    repeat (13) tick();
    checkOutput("held_last", 16'(d_last_o), 16'd1);
    checkOutput("held_no_overlap", 16'(blk_ready_o), 16'd0);
    tick();
    checkOutput("held_ready", 16'(blk_ready_o), 16'd1);
    checkOutput("held_gap", 16'(d_valid_o), 16'd0);
    tick();
    checkOutput("held_accept", 16'(d_valid_o), 16'd1);
    checkOutput("held_round0", 16'(round_o), 16'd0);
    checkOutput("held_d0", 16'(d_o), 16'h2A7);
    blk_valid_i = 1'b0;
    repeat (14) tick();
    checkOutput("final_ready", 16'(blk_ready_o), 16'd1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
